div_seq: RTL

Sequential signed 32-bit divider for the multicycle CPU datapath. It sits directly upstream of the Hi/Lo input multiplexers. It takes the DIV A/B operands (selected from A, B or MDR) and produces remainder (Hi) and quotient (Lo) for the `div`/`divm` instructions. It signals completion and divide-by-zero to the control unit, which gates the HiCtrl/LoCtrl writes and the exception path.

---
 rtl/div_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: sequential signed divider (MIPS div semantics).
// Restoring division on operand magnitudes, one quotient bit per cycle,
// followed by a single sign-correction cycle. hi_out = remainder, lo_out = quotient.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; results held
// S_RUN    | WIDTH restoring iterations, one quotient bit per cycle
// S_FIX    | apply signs, register hi_out/lo_out, raise done
// S_DONE_Z | divisor was zero: done/div_zero high, results untouched
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FIX    = 2'd2,
    S_DONE_Z = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             trial_ok;
  logic             accept, accept_zero;

  // Operand magnitudes use WIDTH-bit negation, so the most negative value maps to itself.
  always_comb begin
    a_abs = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    b_abs = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
  end

  // One restoring step. The partial remainder always stays below |b|, so WIDTH bits hold it;
  // the borrow out of the (WIDTH+1)-bit subtraction tells whether the trial succeeded.
  always_comb begin
    rem_sh   = {rem, quot[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, b_mag};
    trial_ok = ~rem_sub[WIDTH];
  end

  // Next-state decode and busy output.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    accept      = 1'b0;
    accept_zero = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (b_in == '0) begin
            accept_zero = 1'b1;
            state_nxt   = S_DONE_Z;
          end else begin
            accept    = 1'b1;
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_DONE_Z: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Completion flags, registered so they appear the cycle after FIX or the zero-divisor accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= (state == S_FIX) || accept_zero;
      div_zero <= accept_zero;
    end
  end

  // Datapath: operand capture, iteration and sign correction of the results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_mag  <= '0;
      quot   <= '0;
      rem    <= '0;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      if (accept) begin
        sign_a <= a_in[WIDTH-1];
        sign_b <= b_in[WIDTH-1];
        b_mag  <= b_abs;
        quot   <= a_abs;
        rem    <= '0;
        cnt    <= CW'(WIDTH);
      end else if (state == S_RUN) begin
        rem  <= trial_ok ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], trial_ok};
        cnt  <= cnt - 1'b1;
      end else if (state == S_FIX) begin
        lo_out <= (sign_a ^ sign_b) ? (~quot + 1'b1) : quot;
        hi_out <= sign_a ? (~rem + 1'b1) : rem;
      end
    end
  end

endmodule
